// File: rtl/dev_bus_pkg.sv
// Shared types and device map for the processor-side device bus.
// Holds the arbiter state encoding and the legality rule reused by the bridge.
package dev_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] TC_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC_LAST = 32'h0000_7F08;
    localparam logic [31:0] OD_A    = 32'h0000_7F14;
    localparam logic [31:0] OD_B    = 32'h0000_7F18;
    localparam logic [31:0] ID_A    = 32'h0000_7F20;

    // Address is widened to 64 bits so callers of any width up to that compare exactly.
    function automatic logic addr_legal(input logic [63:0] addr, input logic we);
        logic ok;
        ok = 1'b0;
        if (addr[1:0] == 2'b00) begin
            if (addr >= 64'(TC_BASE) && addr <= 64'(TC_LAST)) begin
                ok = 1'b1;
            end else if (addr == 64'(OD_A) || addr == 64'(OD_B)) begin
                ok = 1'b1;
            end else if (addr == 64'(ID_A)) begin
                ok = ~we;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// Two-master request/ack bus plus the single bridge port behind the arbiter.
// The slave modport is the arbiter's view; master is the masters/bridge side.
interface dev_bus_arbiter_if
    import dev_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wd;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rd;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wd;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rd;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wd;
    logic              bus_we;
    logic [DATA_W-1:0] bus_rd;
    logic              busy;
    logic              gnt_id;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        input  bus_rd,
        output m0_ack, m0_err, m0_rd,
        output m1_ack, m1_err, m1_rd,
        output bus_addr, bus_wd, bus_we, busy, gnt_id
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        output m1_req, m1_we, m1_addr, m1_wd,
        output bus_rd,
        input  m0_ack, m0_err, m0_rd,
        input  m1_ack, m1_err, m1_rd,
        input  bus_addr, bus_wd, bus_we, busy, gnt_id
    );

endinterface

// File: rtl/dev_addr_check.sv
// Combinational legality decode of a word access against the device map.
// Zero latency, no state; shared between the arbiter and the bridge.
module dev_addr_check
    import dev_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic              legal
);

    assign legal = addr_legal(64'(addr), we);

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin two-master arbiter onto the device bridge; ack/err two cycles after req.
// One access per three cycles; the losing master simply holds req until granted.
module dev_bus_arbiter
    import dev_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    dev_bus_arbiter_if.slave bus
);

    state_t                 state_q, state_d;
    logic                   last_id_q, last_id_d;
    logic                   gnt_id_q, gnt_id_d;
    logic                   busy_q, busy_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_wd_q, bus_wd_d;
    logic                   bus_we_q, bus_we_d;
    logic                   we_q, we_d;
    logic                   ok_q, ok_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rd_q, rd_d;

    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;
    logic              sel_legal;

    // On a tie the master that did not win last time goes next.
    always_comb begin
        win = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            win = ~last_id_q;
        end else if (bus.m1_req) begin
            win = 1'b1;
        end
        sel_we   = win ? bus.m1_we   : bus.m0_we;
        sel_addr = win ? bus.m1_addr : bus.m0_addr;
        sel_wd   = win ? bus.m1_wd   : bus.m0_wd;
    end

    dev_addr_check #(
        .ADDR_W (ADDR_W)
    ) u_addr_check (
        .addr  (sel_addr),
        .we    (sel_we),
        .legal (sel_legal)
    );

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        bus_addr_d = bus_addr_q;
        bus_wd_d   = bus_wd_q;
        we_d       = we_q;
        ok_d       = ok_q;
        rd_d       = rd_q;
        bus_we_d   = 1'b0;
        ack_d      = 2'b00;
        err_d      = 2'b00;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d    = ISSUE;
                    busy_d     = 1'b1;
                    gnt_id_d   = win;
                    bus_addr_d = sel_addr;
                    bus_wd_d   = sel_wd;
                    we_d       = sel_we;
                    ok_d       = sel_legal;
                    // Illegal writes still present the address but never strobe the bridge.
                    bus_we_d   = sel_we & sel_legal;
                end
            end
            ISSUE: begin
                state_d   = DONE;
                busy_d    = 1'b1;
                last_id_d = gnt_id_q;
                if (!we_q && ok_q) begin
                    rd_d[gnt_id_q] = bus.bus_rd;
                end
                ack_d[gnt_id_q] = ok_q;
                err_d[gnt_id_q] = ~ok_q;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_id_q  <= 1'b1;
            gnt_id_q   <= 1'b0;
            busy_q     <= 1'b0;
            bus_addr_q <= '0;
            bus_wd_q   <= '0;
            bus_we_q   <= 1'b0;
            we_q       <= 1'b0;
            ok_q       <= 1'b0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            bus_addr_q <= bus_addr_d;
            bus_wd_q   <= bus_wd_d;
            bus_we_q   <= bus_we_d;
            we_q       <= we_d;
            ok_q       <= ok_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_wd   = bus_wd_q;
    assign bus.bus_we   = bus_we_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rd    = rd_q[0];
    assign bus.m1_rd    = rd_q[1];

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares every ack/err pulse.
module tb_dev_bus_arbiter;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [3:0]  mon_got;
    logic [3:0]  mon_exp;
    logic [31:0] mrd[2];

    dev_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    dev_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit m, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m) begin
            bif.m1_req = req; bif.m1_we = we; bif.m1_addr = addr; bif.m1_wd = wd;
        end else begin
            bif.m0_req = req; bif.m0_we = we; bif.m0_addr = addr; bif.m0_wd = wd;
        end
    endtask

    task automatic expect_resp(input bit m, input bit err, input int at_cyc);
        exp_t e;
        e.m   = m;
        e.err = err;
        e.rd  = mrd[m];
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    // Single access: req presented in cycle k, ISSUE in k+1, response in k+2, req dropped in k+3.
    task automatic access(input bit m, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_err);
        int k;
        @(posedge clk); #1;
        k = cyc;
        drive(m, 1'b1, we, addr, wd);
        if (!we && !exp_err) mrd[m] = bif.bus_rd;
        expect_resp(m, exp_err, k + 2);
        @(negedge clk);
        check("bus_we_req_cycle", 32'(bif.bus_we), 32'd0);
        @(negedge clk);
        check("bus_we_issue", 32'(bif.bus_we), 32'(we & ~exp_err));
        check("bus_addr_issue", bif.bus_addr, addr);
        if (we) check("bus_wd_issue", bif.bus_wd, wd);
        check("gnt_id_issue", 32'(bif.gnt_id), 32'(m));
        check("busy_issue", 32'(bif.busy), 32'd1);
        @(negedge clk);
        check("bus_we_done", 32'(bif.bus_we), 32'd0);
        check("bus_addr_done", bif.bus_addr, addr);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bus_addr"}, bif.bus_addr, 32'd0);
        check({tag, "_bus_wd"}, bif.bus_wd, 32'd0);
        check({tag, "_bus_we"}, 32'(bif.bus_we), 32'd0);
        check({tag, "_pulses"}, 32'({bif.m0_ack, bif.m0_err, bif.m1_ack, bif.m1_err}), 32'd0);
        check({tag, "_m0_rd"}, bif.m0_rd, 32'd0);
        check({tag, "_m1_rd"}, bif.m1_rd, 32'd0);
        check({tag, "_busy"}, 32'(bif.busy), 32'd0);
        check({tag, "_gnt_id"}, 32'(bif.gnt_id), 32'd0);
    endtask

    // Scoreboard monitor: every ack/err pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        mon_got = {bif.m0_ack, bif.m0_err, bif.m1_ack, bif.m1_err};
        if ((|mon_got) === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got pulses %b expected none (cycle %0d)", mon_got, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.m) mon_exp = mon_e.err ? 4'b0001 : 4'b0010;
                else         mon_exp = mon_e.err ? 4'b0100 : 4'b1000;
                check("resp_kind", 32'(mon_got), 32'(mon_exp));
                check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("resp_rd", mon_e.m ? bif.m1_rd : bif.m0_rd, mon_e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        checks = 0;
        errors = 0;
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        bif.bus_rd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("post_rst");

        // m0 legal write
        access(1'b0, 1'b1, 32'h0000_7F04, 32'h0000_00AA, 1'b0);

        // m1 legal read from input device; read data must survive bus_rd changing
        bif.bus_rd = 32'h1234_5678;
        access(1'b1, 1'b0, 32'h0000_7F20, 32'd0, 1'b0);
        bif.bus_rd = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("m1_rd_held", bif.m1_rd, 32'h1234_5678);

        // both masters held for three accesses each: m0 reads timer, m1 writes output device
        bif.bus_rd = 32'hCAFE_0001;
        @(posedge clk); #1;
        k = cyc;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_7F00, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_7F18, 32'h0000_0055);
        mrd[0] = 32'hCAFE_0001;
        for (int i = 0; i < 6; i++) expect_resp(i[0], 1'b0, k + 2 + 3 * i);
        for (int d = 0; d < 18; d++) begin
            @(negedge clk);
            if (d % 3 == 1) begin
                check("rr_gnt_id", 32'(bif.gnt_id), 32'((d / 3) % 2));
                check("rr_busy_issue", 32'(bif.busy), 32'd1);
                check("rr_bus_we", 32'(bif.bus_we), 32'((d / 3) % 2));
                check("rr_bus_addr", bif.bus_addr,
                      ((d / 3) % 2 == 1) ? 32'h0000_7F18 : 32'h0000_7F00);
            end else if (d % 3 == 0 && d > 0) begin
                check("rr_busy_gap", 32'(bif.busy), 32'd0);
            end else begin
                check("rr_busy_done", 32'(bif.busy), 32'(d != 0));
            end
            @(posedge clk); #1;
            if (d + 1 == 15) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // illegal accesses: all err, no bridge write, read data untouched
        bif.bus_rd = 32'h0BAD_F00D;
        access(1'b0, 1'b1, 32'h0000_7F20, 32'h0000_0011, 1'b1);
        access(1'b1, 1'b0, 32'h0000_7F02, 32'd0, 1'b1);
        access(1'b0, 1'b0, 32'h0000_8000, 32'd0, 1'b1);
        @(negedge clk);
        check("err_m0_rd_kept", bif.m0_rd, 32'hCAFE_0001);
        check("err_m1_rd_kept", bif.m1_rd, 32'h1234_5678);

        // reset during ISSUE of a legal write
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_7F14, 32'h0000_0077);
        @(negedge clk);
        @(negedge clk);
        check("rst_issue_bus_we", 32'(bif.bus_we), 32'd1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_reset_state("mid_rst");
        @(posedge clk); #1;
        reset  = 1'b0;
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        @(negedge clk);
        check("after_rst_busy", 32'(bif.busy), 32'd0);
        access(1'b0, 1'b1, 32'h0000_7F14, 32'h0000_0077, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dev_bus_arbiter.md
# dev_bus_arbiter

Two-master arbiter in front of the processor-side device bridge. It shares the single bridge port (address, write data, write enable, read data) between the CPU data port (master 0) and a second bus master such as a DMA or debug engine (master 1). It serialises one word access at a time, picks between masters round-robin, rejects illegal device accesses before they reach the bridge, and returns read data with a one-cycle acknowledge.

## Interface
- ADDR_W, 32, address width of masters and bridge port
- DATA_W, 32, data width
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held until ack or err
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  ADDR_W  byte address; stable while req high
- m0_wd / m1_wd  in  DATA_W  write data; stable while req high
- m0_ack / m1_ack  out  1  one-cycle pulse: access completed
- m0_err / m1_err  out  1  one-cycle pulse: access rejected, no bus effect
- m0_rd / m1_rd  out  DATA_W  read data, valid in the ack cycle, held until next ack to that master
- bus_addr  out  ADDR_W  registered address to bridge
- bus_wd  out  DATA_W  registered write data to bridge
- bus_we  out  1  bridge write enable, one cycle per legal write
- bus_rd  in  DATA_W  bridge read data, combinational from bus_addr
- busy  out  1  high in any state other than IDLE
- gnt_id  out  1  master owning the current/last transaction

## Operation
- States: IDLE, ISSUE, DONE. Reset → IDLE.
- IDLE: no req → stay. Any req → pick winner, latch its addr/wd/we into bus_addr/bus_wd/we_q, set gnt_id, evaluate legality, → ISSUE.
- Round-robin: pointer last_id (reset 1, so m0 wins the first tie). Both req → winner = !last_id. Single req → that master. last_id ← winner on entering DONE.
- Legality (decided at latch, stored as ok_q):
  - addr[1:0] ≠ 0 → illegal.
  - Timer window 0x7F00, 0x7F04, 0x7F08: read/write.
  - Output device 0x7F14, 0x7F18: read/write.
  - Input device 0x7F20: read only; write illegal.
  - Anything else illegal.
- ISSUE: bus_we = we_q & ok_q for this cycle only. If read and ok_q, rd_q[winner] ← bus_rd. → DONE.
- DONE: ok_q → ack[winner] = 1, else err[winner] = 1. → IDLE unconditionally.
- Masters sample ack/err and must drop or change req by the cycle after the pulse. A req still high in the IDLE after DONE is a new access.
- Loser's req is untouched. It wins the next IDLE because of the round-robin pointer.
- Illegal access: bus_addr is still updated, bus_we stays 0, and m*_rd is not updated.

## Timing
- Latency: req seen in IDLE at cycle T → bus_addr valid T+1 (ISSUE) → ack/err at T+2 (DONE). Earliest next latch at T+3.
- Throughput: one access per 3 cycles. A competing master is served at the latest 3 cycles after the current one.
- Reset values: state IDLE, bus_addr 0, bus_wd 0, bus_we 0, m0/m1_ack 0, m0/m1_err 0, m0/m1_rd 0, busy 0, gnt_id 0, last_id 1.
- Reset mid-ISSUE: the write is not performed if reset is sampled on that edge. No ack/err is issued; the master must re-request.
- Reset mid-DONE: the pending ack/err is dropped. rd_q is already cleared by reset.
- bus_addr/bus_wd only change on the IDLE→ISSUE edge. They are stable through ISSUE and DONE.

## Structure
- Package dev_bus_pkg:
  - state enum (IDLE/ISSUE/DONE)
  - device address constants (TC_BASE 0x7F00, TC_LAST 0x7F08, OD_A 0x7F14, OD_B 0x7F18, ID_A 0x7F20)
  - function addr_legal(addr, we)
- Sub-module dev_addr_check: purely combinational legality decode, reused later by the bridge.
- Arbiter FSM, round-robin pointer, and per-master rd registers stay in dev_bus_arbiter.

## Test plan
- m0 write 0x0000_00AA to 0x7F04:
  - bus_we high exactly one cycle, 1 cycle after req.
  - m0_ack 2 cycles after req; m1 outputs quiet.
- m1 read 0x7F20 with bus_rd = 0x1234_5678:
  - m1_ack at T+2, m1_rd = 0x1234_5678 and held after bus_rd changes.
- m0 and m1 req together, both held for 3 accesses each:
  - grant order m0, m1, m0, m1, m0, m1.
  - gnt_id alternates; busy low for exactly one cycle between accesses.
- m0 write to 0x7F20, m1 read 0x7F02, m0 read 0x8000:
  - each gets err at T+2 and no ack.
  - bus_we never high; m*_rd unchanged.
- Reset asserted in the ISSUE cycle of a write to 0x7F14:
  - bus_we 0, no ack/err, all outputs at reset values next cycle.
  - The re-requested access then completes normally.
